// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, HS/VS generation and 12-bit test-pattern / external colour source.
// Latency: VGA_HS/VGA_VS/RGB registered one clock behind pix_x/pix_y; pixel rate is CLK100MHZ / CLK_DIV.
// Backpressure: none, free-running raster; define VGA_BORDER_EN to force a white 1-pixel border in modes 1-3.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [1:0]  mode,
    input  logic [3:0]  ext_r,
    input  logic [3:0]  ext_g,
    input  logic [3:0]  ext_b,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_EXT   = 2'd3
    } mode_t;

    logic [DIV_W-1:0] div_cnt;
    logic [11:0]      h_cnt;
    logic [10:0]      v_cnt;
    logic             pix_ce;
    logic             h_last;
    logic             v_last;
    logic             frame_wrap;
    logic             hs_act;
    logic             vs_act;
    logic [2:0]       bar_idx;
    logic             chk_white;
    logic [11:0]      rgb_nxt;
    logic [11:0]      rgb_q;
    mode_t            mode_q;

    assign pix_ce     = (div_cnt == DIV_LAST);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_wrap = pix_ce && h_last && v_last;

    assign pix_x     = h_cnt;
    assign pix_y     = v_cnt;
    assign pix_valid = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            if (pix_ce) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (pix_ce) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Bar index from a comparator ladder against multiples of the bar width.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= 12'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

    assign chk_white = ~(h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]);

`ifdef VGA_BORDER_EN
    localparam logic [11:0] H_EDGE = 12'(H_ACTIVE - 1);
    localparam logic [10:0] V_EDGE = 11'(V_ACTIVE - 1);
    logic on_edge;
    assign on_edge = (h_cnt == 12'd0) || (h_cnt == H_EDGE) ||
                     (v_cnt == 11'd0) || (v_cnt == V_EDGE);
`endif

    always_comb begin
        rgb_nxt = 12'h000;
        if (pix_valid) begin
            case (mode_q)
                MODE_BARS:  rgb_nxt = bar_colour(bar_idx);
                MODE_CHECK: rgb_nxt = chk_white ? 12'hFFF : 12'h000;
                MODE_EXT:   rgb_nxt = {ext_r, ext_g, ext_b};
                default:    rgb_nxt = 12'h000;
            endcase
`ifdef VGA_BORDER_EN
            if ((mode_q != MODE_BLACK) && on_edge) begin
                rgb_nxt = 12'hFFF;
            end
`endif
        end
    end

    // Mode is only taken at the frame wrap so a frame never mixes two patterns.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            mode_q      <= MODE_BLACK;
            frame_start <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            rgb_q       <= 12'h000;
        end else begin
            if (frame_wrap) begin
                mode_q <= mode_t'(mode);
            end
            frame_start <= frame_wrap;
            VGA_HS      <= hs_act ? HS_POL : ~HS_POL;
            VGA_VS      <= vs_act ? VS_POL : ~VS_POL;
            rgb_q       <= rgb_nxt;
        end
    end

    assign VGA_R = rgb_q[11:8];
    assign VGA_G = rgb_q[7:4];
    assign VGA_B = rgb_q[3:0];

endmodule
